// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: instruction word layout,
// FSM state encoding and the default HALT opcode.
package instr_sequencer_pkg;

    // Instruction word layout: {opcode, operand_1, operand_2}
    localparam int INSTR_W  = 16;
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int OPR1_MSB = 11;
    localparam int OPR1_LSB = 8;
    localparam int OPR2_MSB = 7;
    localparam int OPR2_LSB = 0;

    // Opcode that ends a program; it is never presented to the decoder
    localparam logic [3:0] HALT_OPCODE_DEFAULT = 4'hF;

    // State encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_GAP  = ST_GAP,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Host load port and decoder issue port of the instruction sequencer.
//
// Handshakes:
//   load  : a word transfers on a rising edge where load_valid && load_ready.
//           load_ready never depends on load_valid.
//   issue : issue_valid is a one-cycle pulse marking new opcode/operand_1/
//           operand_2; there is no back-pressure (the decoder pauses the
//           sequencer through hold instead). Fields hold between pulses.
interface instr_sequencer_if;
    import instr_sequencer_pkg::*;

    logic               load_valid;
    logic [INSTR_W-1:0] load_data;
    logic               load_ready;

    logic [3:0]         opcode;
    logic [3:0]         operand_1;
    logic [7:0]         operand_2;
    logic               issue_valid;

    // Sequencer side: consumes host loads, produces instructions
    modport master (
        input  load_valid, load_data,
        output load_ready, opcode, operand_1, operand_2, issue_valid
    );

    // Host/decoder side
    modport slave (
        output load_valid, load_data,
        input  load_ready, opcode, operand_1, operand_2, issue_valid
    );

endinterface

// File: rtl/instr_buffer.sv
// Program store: DEPTH x WIDTH words, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module instr_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction issuer feeding the core decoder. The host fills the program
// buffer in IDLE; start steps pc through it, issuing one word every
// ISSUE_GAP cycles until the last word or a HALT opcode, then reports done.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int         DEPTH       = 16,
    parameter int         ADDR_W      = 4,
    parameter int         ISSUE_GAP   = 2,
    parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    instr_sequencer_if.master   bus,
    input  logic                start,
    input  logic                hold,
    input  logic                clear,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                done,
    output state_t              fsm_state,
    output logic [ADDR_W:0]     prog_len
);

    // gap_cnt only has to hold ISSUE_GAP-1
    localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    // prog_len is one bit wider than pc so that a full buffer is representable
    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(DEPTH);

    state_t             state;
    state_t             state_next;
    logic [ADDR_W:0]    len_next;
    logic [ADDR_W:0]    last_idx;
    logic [ADDR_W-1:0]  pc_next;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_next;
    logic [3:0]         opc_next;
    logic [3:0]         opr1_next;
    logic [7:0]         opr2_next;
    logic               iv_next;
    logic               wr_en;
    logic [INSTR_W-1:0] rd_word;

    instr_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (INSTR_W)
    ) u_buffer (
        .clk   (clk),
        .we    (wr_en),
        .waddr (prog_len[ADDR_W-1:0]),
        .wdata (bus.load_data),
        .raddr (pc),
        .rdata (rd_word)
    );

    assign bus.load_ready = (state == S_IDLE) && (prog_len != FULL_LEN);
    assign last_idx       = prog_len - (ADDR_W + 1)'(1);
    assign busy           = (state == S_RUN) || (state == S_GAP);
    assign done           = (state == S_DONE);
    assign fsm_state      = state;

    // Next-state, counter and output-field logic; clear overrides everything
    always_comb begin
        state_next = state;
        len_next   = prog_len;
        pc_next    = pc;
        gap_next   = gap_cnt;
        opc_next   = bus.opcode;
        opr1_next  = bus.operand_1;
        opr2_next  = bus.operand_2;
        iv_next    = 1'b0;
        wr_en      = 1'b0;

        if (clear) begin
            state_next = S_IDLE;
            len_next   = '0;
            pc_next    = '0;
            gap_next   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    wr_en = bus.load_valid && bus.load_ready;
                    if (wr_en) begin
                        len_next = prog_len + (ADDR_W + 1)'(1);
                    end
                    // A word accepted in the same cycle counts toward a runnable program
                    if (start && (len_next != '0)) begin
                        state_next = S_RUN;
                        pc_next    = '0;
                    end
                end
                S_RUN: begin
                    if (!hold) begin
                        if (rd_word[OPC_MSB:OPC_LSB] == HALT_OPCODE) begin
                            state_next = S_DONE;
                        end else begin
                            opc_next  = rd_word[OPC_MSB:OPC_LSB];
                            opr1_next = rd_word[OPR1_MSB:OPR1_LSB];
                            opr2_next = rd_word[OPR2_MSB:OPR2_LSB];
                            iv_next   = 1'b1;
                            // Wraps to 0 when a full buffer finishes
                            pc_next   = pc + ADDR_W'(1);
                            if ({1'b0, pc} == last_idx) begin
                                state_next = S_DONE;
                            end else if (ISSUE_GAP > 1) begin
                                state_next = S_GAP;
                                gap_next   = GAP_W'(ISSUE_GAP - 1);
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (!hold) begin
                        gap_next = gap_cnt - GAP_W'(1);
                        if (gap_cnt == GAP_W'(1)) begin
                            state_next = S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_next = S_RUN;
                        pc_next    = '0;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counters and registered instruction outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            prog_len        <= '0;
            pc              <= '0;
            gap_cnt         <= '0;
            bus.opcode      <= '0;
            bus.operand_1   <= '0;
            bus.operand_2   <= '0;
            bus.issue_valid <= 1'b0;
        end else begin
            prog_len        <= len_next;
            pc              <= pc_next;
            gap_cnt         <= gap_next;
            bus.opcode      <= opc_next;
            bus.operand_1   <= opr1_next;
            bus.operand_2   <= opr2_next;
            bus.issue_valid <= iv_next;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer (DEPTH=16, ISSUE_GAP=2).
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       hold;
    logic       clear;
    logic [3:0] pc;
    logic       busy;
    logic       done;
    state_t     fsm_state;
    logic [4:0] prog_len;

    instr_sequencer_if bus ();

    instr_sequencer #(
        .DEPTH       (16),
        .ADDR_W      (4),
        .ISSUE_GAP   (2),
        .HALT_OPCODE (4'hF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .start     (start),
        .hold      (hold),
        .clear     (clear),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .fsm_state (fsm_state),
        .prog_len  (prog_len)
    );

    // ---------------- clock / reset / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Scoreboard: expected and observed issued words, plus pulse timestamps
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          cyc_q[$];

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.issue_valid === 1'b1) begin
            got_q.push_back({bus.opcode, bus.operand_1, bus.operand_2});
            cyc_q.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        got_q.delete();
        cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic load_word(input logic [15:0] w);
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        step();
        bus.load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Waits for done, then one more cycle so the monitor sees the last pulse
    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
    endtask

    task automatic wait_issue(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.issue_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (bus.opcode !== 4'h0) begin errors++; $display("FAIL reset_opcode got=%h exp=0", bus.opcode); end
        checks++; if (bus.operand_1 !== 4'h0) begin errors++; $display("FAIL reset_operand_1 got=%h exp=0", bus.operand_1); end
        checks++; if (bus.operand_2 !== 8'h00) begin errors++; $display("FAIL reset_operand_2 got=%h exp=0", bus.operand_2); end
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got=%b exp=0", bus.issue_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        checks++; if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        checks++; if (prog_len !== 5'd0) begin errors++; $display("FAIL reset_prog_len got=%0d exp=0", prog_len); end
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, S_IDLE); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got=%b exp=1", bus.load_ready); end
    endtask

    task automatic test_basic_issue();
        bit ok;
        int st_cyc;
        do_reset();
        load_word(16'h1234);
        load_word(16'h2A05);
        load_word(16'h3B80);
        exp_q = '{16'h1234, 16'h2A05, 16'h3B80};
        pulse_start();
        st_cyc = cyc;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got=no_done exp=done"); end
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL basic_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        if (cyc_q.size() == 3) begin
            checks++; if (cyc_q[0] !== st_cyc + 2) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", cyc_q[0] - st_cyc, 2); end
            checks++; if (cyc_q[1] - cyc_q[0] !== 2) begin errors++; $display("FAIL basic_gap1 got=%0d exp=2", cyc_q[1] - cyc_q[0]); end
            checks++; if (cyc_q[2] - cyc_q[1] !== 2) begin errors++; $display("FAIL basic_gap2 got=%0d exp=2", cyc_q[2] - cyc_q[1]); end
        end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done got=%b%b exp=10", done, busy); end
        checks++; if (pc !== 4'd3) begin errors++; $display("FAIL basic_pc got=%0d exp=3", pc); end
        checks++; if ({bus.opcode, bus.operand_1, bus.operand_2} !== 16'h3B80) begin
            errors++; $display("FAIL basic_fields_held got=%h exp=3b80", {bus.opcode, bus.operand_1, bus.operand_2});
        end
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL basic_done_load_ready got=%b exp=0", bus.load_ready); end
    endtask

    task automatic test_halt();
        bit ok;
        int n_op2;
        do_reset();
        load_word(16'h1001);
        load_word(16'hF000);
        load_word(16'h2002);
        pulse_start();
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL halt_timeout got=no_done exp=done"); end
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL halt_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0] !== 16'h1001) begin errors++; $display("FAIL halt_word got=%h exp=1001", got_q[0]); end
        end
        n_op2 = 0;
        foreach (got_q[i]) if (got_q[i][15:12] == 4'h2) n_op2++;
        checks++; if (n_op2 !== 0) begin errors++; $display("FAIL halt_op2_seen got=%0d exp=0", n_op2); end
        checks++; if (pc !== 4'd1) begin errors++; $display("FAIL halt_pc got=%0d exp=1", pc); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_done got=%b exp=1", done); end
    endtask

    task automatic test_full_buffer();
        bit ok;
        logic [15:0] w;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            w = 16'h1000 + 16'(i) * 16'h0111;
            exp_q.push_back(w);
            checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL full_ready%0d got=%b exp=1", i, bus.load_ready); end
            load_word(w);
        end
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after16 got=%b exp=0", bus.load_ready); end
        checks++; if (prog_len !== 5'd16) begin errors++; $display("FAIL full_len16 got=%0d exp=16", prog_len); end
        load_word(16'h5555);
        checks++; if (prog_len !== 5'd16) begin errors++; $display("FAIL full_drop17 got=%0d exp=16", prog_len); end
        pulse_start();
        wait_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_timeout got=no_done exp=done"); end
        checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL full_count got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (pc !== 4'd0) begin errors++; $display("FAIL full_pc_wrap got=%0d exp=0", pc); end
    endtask

    task automatic test_hold();
        bit ok;
        do_reset();
        load_word(16'h1234);
        load_word(16'h2A05);
        load_word(16'h3B80);
        pulse_start();
        wait_issue(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_first_timeout got=no_issue exp=issue"); end
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL hold_iv%0d got=%b exp=0", i, bus.issue_valid); end
            checks++; if ({bus.opcode, bus.operand_1, bus.operand_2} !== 16'h1234) begin
                errors++; $display("FAIL hold_fields%0d got=%h exp=1234", i, {bus.opcode, bus.operand_1, bus.operand_2});
            end
        end
        hold = 1'b0;
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_timeout got=no_done exp=done"); end
        checks++; if (cyc_q.size() !== 3) begin errors++; $display("FAIL hold_count got=%0d exp=3", cyc_q.size()); end
        if (cyc_q.size() == 3) begin
            checks++; if (cyc_q[1] - cyc_q[0] !== 7) begin errors++; $display("FAIL hold_delay got=%0d exp=7", cyc_q[1] - cyc_q[0]); end
            checks++; if (cyc_q[2] - cyc_q[1] !== 2) begin errors++; $display("FAIL hold_gap_after got=%0d exp=2", cyc_q[2] - cyc_q[1]); end
            checks++; if (got_q[1] !== 16'h2A05) begin errors++; $display("FAIL hold_word1 got=%h exp=2a05", got_q[1]); end
        end
    endtask

    task automatic test_clear();
        bit ok;
        do_reset();
        load_word(16'h1234);
        load_word(16'h2A05);
        load_word(16'h3B80);
        pulse_start();
        wait_issue(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clear_first_timeout got=no_issue exp=issue"); end
        checks++; if (fsm_state !== S_GAP) begin errors++; $display("FAIL clear_in_gap got=%0d exp=%0d", fsm_state, S_GAP); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL clear_state got=%0d exp=%0d", fsm_state, S_IDLE); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy got=%b exp=0", busy); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL clear_load_ready got=%b exp=1", bus.load_ready); end
        checks++; if (pc !== 4'd0 || prog_len !== 5'd0) begin errors++; $display("FAIL clear_counters got=pc%0d/len%0d exp=pc0/len0", pc, prog_len); end
        checks++; if ({bus.opcode, bus.operand_1, bus.operand_2} !== 16'h1234) begin
            errors++; $display("FAIL clear_fields_kept got=%h exp=1234", {bus.opcode, bus.operand_1, bus.operand_2});
        end
        repeat (10) step();
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL clear_no_more_pulses got=%0d exp=1", got_q.size()); end
        pulse_start();
        step();
        checks++; if (fsm_state !== S_IDLE || busy !== 1'b0) begin
            errors++; $display("FAIL clear_empty_start got=state%0d/busy%b exp=state0/busy0", fsm_state, busy);
        end
    endtask

    task automatic test_rerun_and_reset();
        bit ok;
        do_reset();
        load_word(16'h4321);
        load_word(16'h5A5A);
        pulse_start();
        wait_done(50, ok);
        checks++; if (!ok || done !== 1'b1) begin errors++; $display("FAIL rerun_first_done got=%b exp=1", done); end
        got_q.delete();
        cyc_q.delete();
        exp_q = '{16'h4321, 16'h5A5A};
        pulse_start();
        checks++; if (fsm_state !== S_RUN || pc !== 4'd0) begin
            errors++; $display("FAIL rerun_restart got=state%0d/pc%0d exp=state1/pc0", fsm_state, pc);
        end
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rerun_timeout got=no_done exp=done"); end
        checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL rerun_count got=%0d exp=2", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rerun_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (pc !== 4'd2) begin errors++; $display("FAIL rerun_pc got=%0d exp=2", pc); end
        // Reset in the middle of a third run
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({bus.opcode, bus.operand_1, bus.operand_2} !== 16'h0000) begin
            errors++; $display("FAIL rst_mid_fields got=%h exp=0000", {bus.opcode, bus.operand_1, bus.operand_2});
        end
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_iv got=%b exp=0", bus.issue_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_done got=%b%b exp=00", busy, done); end
        checks++; if (pc !== 4'd0 || prog_len !== 5'd0) begin errors++; $display("FAIL rst_mid_counters got=pc%0d/len%0d exp=pc0/len0", pc, prog_len); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        hold           = 1'b0;
        clear          = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 16'h0000;

        test_reset();
        test_basic_issue();
        test_halt();
        test_full_buffer();
        test_hold();
        test_clear();
        test_rerun_and_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction issuer that feeds the RISC core's decode inputs (opcode, operand_1, operand_2). It is the producer end of the instruction interface the decoder consumes.
- A host loads a short program of 16-bit instruction words into an internal buffer. On start, the block steps a program counter and issues one instruction every ISSUE_GAP cycles.
- Issuing ends at the end of the program, or on a HALT opcode, and the block then reports done.

Parameters:
- DEPTH, 16, number of instruction words in the buffer (power of two).
- ADDR_W, 4, log2(DEPTH); width of pc and length counters.
- ISSUE_GAP, 2, clock cycles between successive issues (>=1); covers the core's RAM/ALU latency.
- HALT_OPCODE, 4'hF, opcode that terminates execution without being issued.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  host offers load_data.
- load_data  in  16  instruction word {opcode[15:12], operand_1[11:8], operand_2[7:0]}.
- load_ready  out  1  buffer accepts a word this cycle.
- start  in  1  begin or rerun the program from pc=0.
- hold  in  1  pause issuing while high.
- clear  in  1  discard the program and return to IDLE.
- opcode  out  4  issued opcode (registered).
- operand_1  out  4  issued operand_1 / register address (registered).
- operand_2  out  8  issued immediate (registered).
- issue_valid  out  1  one-cycle pulse: the instruction fields are new this cycle.
- pc  out  ADDR_W  index of the next word to issue.
- busy  out  1  state is RUN or GAP.
- done  out  1  state is DONE.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; prog_len=0; pc=0; gap_cnt=0.
  - opcode, operand_1, operand_2 and issue_valid all 0; busy=0, done=0.
  - Buffer contents are not reset. rst overrides every other input, including mid-run.
- States: IDLE, RUN, GAP, DONE. busy and done decode combinationally from state; all other outputs are registered.
- IDLE:
  - load_ready = (prog_len != DEPTH). It does not depend on load_valid or start.
  - Accepted load: buf[prog_len] <= load_data; prog_len++. When full, load_ready=0 and loads are dropped.
  - start with prog_len_next != 0 (prog_len_next counts a load accepted in the same cycle) -> RUN, pc=0.
  - start with prog_len_next == 0 is ignored.
  - load_ready=0 in every state other than IDLE.
- RUN:
  - If hold=1: no action; issue_valid=0.
  - Else, if buf[pc].opcode == HALT_OPCODE: no issue; go to DONE; pc unchanged.
  - Else: register the fields of buf[pc] onto the outputs; issue_valid=1 for the next cycle; pc++. Then:
    - If pc was prog_len-1, go to DONE.
    - Else if ISSUE_GAP>1, go to GAP with gap_cnt=ISSUE_GAP-1.
    - Else stay in RUN.
- GAP:
  - hold freezes gap_cnt.
  - Otherwise gap_cnt decrements; when gap_cnt==1 the next state is RUN.
  - Net effect: with no hold, successive issue_valid pulses are exactly ISSUE_GAP cycles apart.
- Latency: start sampled at edge E0 -> first issue_valid high in the cycle after E1.
- Instruction fields hold their last issued value between pulses. issue_valid is never high for two consecutive cycles unless ISSUE_GAP=1.
- DONE:
  - done=1.
  - start -> RUN with pc=0; the program is retained.
  - Loads are not accepted.
- clear (any state, no rst): state=IDLE, prog_len=0, pc=0, issue_valid=0. Instruction fields keep their values. clear has priority over start and load.
- pc wraps modulo DEPTH only through the end-of-program check. pc never exceeds prog_len.

Decomposition:
- Shared package holds:
  - instruction field positions (OPC_MSB/LSB, OPR1_MSB/LSB, OPR2_MSB/LSB);
  - the state encoding localparams;
  - HALT_OPCODE default.
- One sub-module, instr_buffer: DEPTH x 16 synchronous-write, asynchronous-read array with write enable. The sequencer holds the FSM, counters and output registers.

Test Plan:
1. ISSUE_GAP=2: load 0x1234, 0x2A05, 0x3B80; start -> three issue_valid pulses 2 cycles apart; opcode=1,2,3; operand_1=2,A,B; operand_2=0x34,0x05,0x80; then done=1 and pc=3.
2. Load 0x1001, 0xF000, 0x2002; start -> only 0x1001 issues; then done=1 with pc=1, and opcode 2 never appears.
3. Load 16 words -> load_ready=0 after the 16th; a 17th load_valid is dropped (prog_len stays 16); start issues all 16 and pc ends at 0 (wrapped).
4. Assert hold for 5 cycles after the first issue of a 3-word run -> the second pulse is delayed by exactly 5 cycles; fields are unchanged during hold.
5. clear in GAP after the first issue -> IDLE, busy=0, no further pulses, load_ready=1. start with nothing loaded -> stays IDLE.
6. rst during RUN -> all outputs 0 on the next cycle; prog_len=0. In DONE, start reruns the retained program from pc=0 (checked before the reset).
